// File: rtl/bip_acc_stack.sv
// BIP accumulator with a folded ALU op, status flags, optional signed saturation
// and a small LIFO that saves and restores the accumulator.
module bip_acc_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter bit SAT   = 1'b0
) (
   input  logic                       clk,
   input  logic                       Reset,
   input  logic                       Clear,
   input  logic [WIDTH-1:0]           Entrada,
   input  logic                       WrAcc,
   input  logic [2:0]                 Op,
   input  logic                       Push,
   input  logic                       Pop,
   output logic [WIDTH-1:0]           Salida,
   output logic                       Zero,
   output logic                       Neg,
   output logic                       Carry,
   output logic                       Ovf,
   output logic [$clog2(DEPTH+1)-1:0] StackCount,
   output logic                       StackFull,
   output logic                       StackEmpty,
   output logic                       StackErr
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {
      OP_LOAD = 3'b000,
      OP_ADD  = 3'b001,
      OP_SUB  = 3'b010,
      OP_AND  = 3'b011,
      OP_OR   = 3'b100,
      OP_XOR  = 3'b101,
      OP_SRA1 = 3'b110,
      OP_HOLD = 3'b111
   } op_e;

   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0]            acc_q, acc_d;
   logic                        carry_q, carry_d;
   logic                        ovf_q, ovf_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic                        err_q, err_d;
   logic [DEPTH-1:0][WIDTH-1:0] stack_q;

   logic                        stk_we;
   logic [PW-1:0]               stk_wa;
   logic [CW-1:0]               cnt_m1;
   logic [PW-1:0]               push_idx, top_idx;
   logic                        full, empty;
   logic [WIDTH:0]              sum, diff;
   logic                        add_ovf, sub_ovf;
   logic [WIDTH-1:0]            sat_val;

   assign full     = (cnt_q == CW'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign cnt_m1   = cnt_q - CW'(1);
   assign push_idx = cnt_q[PW-1:0];
   assign top_idx  = cnt_m1[PW-1:0];

   assign sum     = {1'b0, acc_q} + {1'b0, Entrada};
   assign diff    = {1'b0, acc_q} - {1'b0, Entrada};
   assign add_ovf = (acc_q[WIDTH-1] == Entrada[WIDTH-1]) && (sum[WIDTH-1]  != acc_q[WIDTH-1]);
   assign sub_ovf = (acc_q[WIDTH-1] != Entrada[WIDTH-1]) && (diff[WIDTH-1] != acc_q[WIDTH-1]);
   // On signed overflow the true result has the sign of the accumulator operand.
   assign sat_val = acc_q[WIDTH-1] ? SMIN : SMAX;

   always_comb begin
      acc_d   = acc_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      stk_we  = 1'b0;
      stk_wa  = push_idx;
      if (Clear) begin
         acc_d   = '0;
         carry_d = 1'b0;
         ovf_d   = 1'b0;
         err_d   = 1'b0;
      end else if (Pop) begin
         if (empty) begin
            err_d = 1'b1;
         end else begin
            acc_d = stack_q[top_idx];
            if (Push) begin
               stk_we = 1'b1;
               stk_wa = top_idx;
            end else begin
               cnt_d = cnt_m1;
            end
         end
      end else begin
         if (Push) begin
            if (full) begin
               err_d = 1'b1;
            end else begin
               stk_we = 1'b1;
               cnt_d  = cnt_q + CW'(1);
            end
         end
         if (WrAcc) begin
            case (op_e'(Op))
               OP_LOAD: acc_d = Entrada;
               OP_ADD: begin
                  acc_d   = (SAT && add_ovf) ? sat_val : sum[WIDTH-1:0];
                  carry_d = sum[WIDTH];
                  ovf_d   = add_ovf;
               end
               OP_SUB: begin
                  acc_d   = (SAT && sub_ovf) ? sat_val : diff[WIDTH-1:0];
                  carry_d = diff[WIDTH];
                  ovf_d   = sub_ovf;
               end
               OP_AND:  acc_d = acc_q & Entrada;
               OP_OR:   acc_d = acc_q | Entrada;
               OP_XOR:  acc_d = acc_q ^ Entrada;
               OP_SRA1: acc_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
               default: acc_d = acc_q;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         acc_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Stack storage is not reset; emptiness is tracked by the count alone.
   always_ff @(posedge clk) begin
      if (stk_we) stack_q[stk_wa] <= acc_q;
   end

   assign Salida     = acc_q;
   assign Zero       = (acc_q == '0);
   assign Neg        = acc_q[WIDTH-1];
   assign Carry      = carry_q;
   assign Ovf        = ovf_q;
   assign StackCount = cnt_q;
   assign StackFull  = full;
   assign StackEmpty = empty;
   assign StackErr   = err_q;

endmodule

// File: tb/tb_bip_acc_stack.sv
// Directed bench for bip_acc_stack: a wrapping and a saturating instance share stimulus.
module tb_bip_acc_stack;
   logic        clk = 1'b0;
   logic        Reset, Clear, WrAcc, Push, Pop;
   logic [2:0]  Op;
   logic [15:0] Entrada;

   logic [15:0] sal_w, sal_s;
   logic        zero_w, neg_w, carry_w, ovf_w, full_w, empty_w, err_w;
   logic        zero_s, neg_s, carry_s, ovf_s, full_s, empty_s, err_s;
   logic [2:0]  cnt_w, cnt_s;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bip_acc_stack #(.WIDTH(16), .DEPTH(4), .SAT(1'b0)) u_wrap (
      .clk(clk), .Reset(Reset), .Clear(Clear), .Entrada(Entrada), .WrAcc(WrAcc),
      .Op(Op), .Push(Push), .Pop(Pop), .Salida(sal_w), .Zero(zero_w), .Neg(neg_w),
      .Carry(carry_w), .Ovf(ovf_w), .StackCount(cnt_w), .StackFull(full_w),
      .StackEmpty(empty_w), .StackErr(err_w));

   bip_acc_stack #(.WIDTH(16), .DEPTH(4), .SAT(1'b1)) u_sat (
      .clk(clk), .Reset(Reset), .Clear(Clear), .Entrada(Entrada), .WrAcc(WrAcc),
      .Op(Op), .Push(Push), .Pop(Pop), .Salida(sal_s), .Zero(zero_s), .Neg(neg_s),
      .Carry(carry_s), .Ovf(ovf_s), .StackCount(cnt_s), .StackFull(full_s),
      .StackEmpty(empty_s), .StackErr(err_s));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drive one cycle of controls, then sample 1 time unit after the edge.
   task automatic cyc(input logic wr, input logic [2:0] op, input logic [15:0] d,
                      input logic ps, input logic pp, input logic cl);
      WrAcc = wr; Op = op; Entrada = d; Push = ps; Pop = pp; Clear = cl;
      @(posedge clk);
      #1;
      WrAcc = 1'b0; Op = 3'b111; Entrada = '0; Push = 1'b0; Pop = 1'b0; Clear = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; Clear = 1'b0; WrAcc = 1'b0; Push = 1'b0; Pop = 1'b0;
      Op = 3'b111; Entrada = '0;
      #3;
      chk("rst_sal",   32'(sal_w),   32'h0);
      chk("rst_zero",  32'(zero_w),  32'h1);
      chk("rst_neg",   32'(neg_w),   32'h0);
      chk("rst_carry", 32'(carry_w), 32'h0);
      chk("rst_ovf",   32'(ovf_w),   32'h0);
      chk("rst_cnt",   32'(cnt_w),   32'h0);
      chk("rst_empty", 32'(empty_w), 32'h1);
      chk("rst_full",  32'(full_w),  32'h0);
      chk("rst_err",   32'(err_w),   32'h0);
      @(negedge clk);
      Reset = 1'b0;

      // 1: load then add
      cyc(1, 3'b000, 16'hC33F, 0, 0, 0);
      cyc(1, 3'b001, 16'h1320, 0, 0, 0);
      chk("add_sal",   32'(sal_w),   32'hD65F);
      chk("add_neg",   32'(neg_w),   32'h1);
      chk("add_carry", 32'(carry_w), 32'h0);
      chk("add_ovf",   32'(ovf_w),   32'h0);
      chk("add_zero",  32'(zero_w),  32'h0);

      // 2: positive overflow, wrap vs saturate
      cyc(1, 3'b000, 16'h7FFF, 0, 0, 0);
      cyc(1, 3'b001, 16'h0001, 0, 0, 0);
      chk("povf_sal_w",   32'(sal_w),   32'h8000);
      chk("povf_ovf_w",   32'(ovf_w),   32'h1);
      chk("povf_carry_w", 32'(carry_w), 32'h0);
      chk("povf_sal_s",   32'(sal_s),   32'h7FFF);
      chk("povf_ovf_s",   32'(ovf_s),   32'h1);

      // negative overflow on SUB
      cyc(1, 3'b000, 16'h8000, 0, 0, 0);
      cyc(1, 3'b010, 16'h0001, 0, 0, 0);
      chk("novf_sal_w",   32'(sal_w),   32'h7FFF);
      chk("novf_sal_s",   32'(sal_s),   32'h8000);
      chk("novf_ovf_s",   32'(ovf_s),   32'h1);
      chk("novf_carry_w", 32'(carry_w), 32'h0);

      // 3: borrow, then AND keeps carry
      cyc(1, 3'b000, 16'h0007, 0, 0, 0);
      cyc(1, 3'b010, 16'h0008, 0, 0, 0);
      chk("sub_sal",   32'(sal_w),   32'hFFFF);
      chk("sub_carry", 32'(carry_w), 32'h1);
      chk("sub_ovf",   32'(ovf_w),   32'h0);
      chk("sub_neg",   32'(neg_w),   32'h1);
      cyc(1, 3'b011, 16'h0000, 0, 0, 0);
      chk("and_zero",  32'(zero_w),  32'h1);
      chk("and_carry", 32'(carry_w), 32'h1);

      // shift / logic / hold
      cyc(1, 3'b000, 16'h8004, 0, 0, 0);
      cyc(1, 3'b110, 16'h1234, 0, 0, 0);
      chk("sra_sal", 32'(sal_w), 32'hC002);
      cyc(1, 3'b100, 16'h0001, 0, 0, 0);
      chk("or_sal", 32'(sal_w), 32'hC003);
      cyc(1, 3'b101, 16'hFFFF, 0, 0, 0);
      chk("xor_sal", 32'(sal_w), 32'h3FFC);
      cyc(1, 3'b111, 16'hAAAA, 0, 0, 0);
      chk("hold_sal", 32'(sal_w), 32'h3FFC);
      chk("hold_carry", 32'(carry_w), 32'h1);

      // 4: fill stack with 1..4
      cyc(1, 3'b000, 16'h0001, 0, 0, 0);
      cyc(1, 3'b000, 16'h0002, 1, 0, 0);
      cyc(1, 3'b000, 16'h0003, 1, 0, 0);
      cyc(1, 3'b000, 16'h0004, 1, 0, 0);
      chk("push3_cnt", 32'(cnt_w), 32'h3);
      cyc(0, 3'b111, 16'h0000, 1, 0, 0);
      chk("full_cnt",  32'(cnt_w),  32'h4);
      chk("full_flag", 32'(full_w), 32'h1);
      chk("full_err0", 32'(err_w),  32'h0);
      cyc(0, 3'b111, 16'h0000, 1, 0, 0);
      chk("ovpush_err", 32'(err_w), 32'h1);
      chk("ovpush_cnt", 32'(cnt_w), 32'h4);
      chk("ovpush_sal", 32'(sal_w), 32'h0004);
      cyc(1, 3'b000, 16'h9999, 0, 1, 0);
      chk("pop1_sal", 32'(sal_w), 32'h0004);
      chk("pop1_cnt", 32'(cnt_w), 32'h3);
      cyc(0, 3'b111, 16'h0000, 0, 1, 0);
      chk("pop2_sal", 32'(sal_w), 32'h0003);
      cyc(0, 3'b111, 16'h0000, 0, 1, 0);
      chk("pop3_sal", 32'(sal_w), 32'h0002);
      cyc(0, 3'b111, 16'h0000, 0, 1, 0);
      chk("pop4_sal",   32'(sal_w),   32'h0001);
      chk("pop4_empty", 32'(empty_w), 32'h1);
      cyc(0, 3'b111, 16'h0000, 0, 1, 0);
      chk("unpop_sal", 32'(sal_w), 32'h0001);
      chk("unpop_err", 32'(err_w), 32'h1);
      chk("unpop_cnt", 32'(cnt_w), 32'h0);

      // 5: swap
      cyc(1, 3'b000, 16'h00AA, 0, 0, 0);
      cyc(1, 3'b000, 16'h0011, 1, 0, 0);
      cyc(0, 3'b111, 16'h0000, 1, 1, 0);
      chk("swap_sal", 32'(sal_w), 32'h00AA);
      chk("swap_cnt", 32'(cnt_w), 32'h1);
      cyc(0, 3'b111, 16'h0000, 0, 1, 0);
      chk("swpop_sal", 32'(sal_w), 32'h0011);
      chk("swpop_cnt", 32'(cnt_w), 32'h0);

      // 6: clear wins over everything, then async reset empties stack
      cyc(1, 3'b000, 16'h0005, 1, 0, 0);
      chk("pre_clr_cnt", 32'(cnt_w), 32'h1);
      cyc(1, 3'b000, 16'h1234, 1, 0, 1);
      chk("clr_sal",   32'(sal_w),   32'h0);
      chk("clr_zero",  32'(zero_w),  32'h1);
      chk("clr_cnt",   32'(cnt_w),   32'h1);
      chk("clr_err",   32'(err_w),   32'h0);
      chk("clr_carry", 32'(carry_w), 32'h0);
      #2;
      Reset = 1'b1;
      #1;
      chk("arst_cnt",   32'(cnt_w),   32'h0);
      chk("arst_empty", 32'(empty_w), 32'h1);
      chk("arst_cnt_s", 32'(cnt_s),   32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
